event_qualifier: RTL and testbench
==================================

# event_qualifier

Qualifies the raw per-sample `event_flag` produced by the threshold comparison stage into clean, debounced IMU events. It rejects runs shorter than a programmable minimum length and enforces a hold-off window after each event. For every accepted event it emits one record (run length, peak sample) over a valid/ready handshake to the event logger. It sits directly downstream of the threshold comparator and consumes its registered flag plus the matching sample.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `CNT_W`, 8: width of `min_len` and `holdoff` configuration inputs.
- `LEN_W`, 16: width of run-length and event-count fields.
- `clk` in 1: clock; all logic rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: qualifier enable; 0 aborts any in-progress event.
- `event_flag` in 1: registered comparator output.
- `sample_in` in WIDTH signed: sample that produced the current `event_flag`, aligned to it by the caller.
- `min_len` in CNT_W: minimum consecutive flagged cycles for acceptance; 0 is treated as 1.
- `holdoff` in CNT_W: dead cycles after an event ends; 0 means no hold-off.
- `clr_overrun` in 1: single-cycle clear of `overrun`.
- `evt_valid` out 1: record available.
- `evt_ready` in 1: consumer accepts record.
- `evt_len` out LEN_W: flagged cycles in the event, saturating.
- `evt_peak` out WIDTH signed: maximum `sample_in` during the event.
- `evt_count` out LEN_W: accepted events since reset, wraps.
- `overrun` out 1: sticky; a record was dropped.

## Operation
- The state machine has four states. Inputs sample `event_flag` and `sample_in` at each edge.
- IDLE:
  - `enable && event_flag`: set run=1, peak=`sample_in`.
  - Go to ACTIVE if effective `min_len` ≤ 1, else go to QUAL.
- QUAL:
  - Flag=1: run+1, peak=max(peak, sample). Go to ACTIVE when run+1 ≥ `min_len`.
  - Flag=0: return to IDLE. This is a glitch, so no record is emitted and no count is taken.
- ACTIVE:
  - Flag=1: run+1 saturating at 2^LEN_W−1; peak=max.
  - Flag=0: the event ends. Emit record {run, peak}, increment `evt_count`, load timer=`holdoff`.
  - On event end, go to HOLDOFF, or to IDLE if `holdoff`=0.
- HOLDOFF:
  - Flags are ignored.
  - Timer decrements each cycle. Leave to IDLE on the edge where the timer equals 1, so there are exactly `holdoff` dead cycles.
- `enable`=0 in any state: go to IDLE next edge and discard run/peak/timer. A pending output record is unaffected.
- `min_len`/`holdoff` are sampled live. Changes mid-event apply from the next comparison.
- Output buffer is single-entry:
  - New record with buffer empty, or buffer full and `evt_ready`=1 in the same cycle: load the new record; `evt_valid`=1.
  - New record with buffer full and `evt_ready`=0: drop the new record, set `overrun`. The held record is kept and `evt_count` still increments.
  - `evt_valid`/`evt_len`/`evt_peak` stay stable until the handshake completes.
- `clr_overrun` together with a new overrun in the same cycle: `overrun` stays 1.
- Peak comparison is signed. Equal values keep the earlier peak.

## Timing
- Reset values: state IDLE; `evt_valid`=0, `evt_len`=0, `evt_peak`=0, `evt_count`=0, `overrun`=0.
- Latency: when the first flag=0 closing an ACTIVE run is sampled at edge t, `evt_valid` and `evt_count` update at edge t. They are visible in the cycle after t.
- A completed handshake (valid&&ready at edge t) clears `evt_valid` at edge t, unless a new record loads at the same edge.
- Throughput: at most one record per (min_len+1+holdoff) cycles.
- Reset mid-event or mid-handshake: everything returns to reset values on the reset edge; the pending record is lost.

## Configuration
- `EVENT_PEAK_CAPTURE_EN` defined: peak tracking as above.
- Not defined: no peak registers or comparator are built, and `evt_peak` is driven constant 0. All other behaviour is identical and the port list is unchanged.

## Structure
- `event_qualifier_pkg`: state enum (IDLE, QUAL, ACTIVE, HOLDOFF), default widths, and the record struct {len, peak}.
- One sub-module, `event_record_buf`: the single-entry valid/ready holding register with overrun detection.
- The FSM, run/peak/timer and counter live in the top module.

## Test plan
- Glitch reject: min_len=4; flag high 3 cycles then low → no `evt_valid`, `evt_count`=0.
- Accept: min_len=4, holdoff=0; flag high 6 cycles with samples 10,50,30,70,20,5 → one record, len=6, peak=70, count=1. Without the macro, peak=0.
- Hold-off: holdoff=5; second 4-cycle run starts 3 cycles after the first ends → ignored. Repeat starting at 6 cycles after → accepted, count=2.
- Backpressure: `evt_ready`=0; two events complete → first record held, `overrun`=1, count=2. Raise ready → one handshake, `evt_valid` drops.
- Simultaneous: second record ends on the same edge the first is accepted → new record loads, `evt_valid` stays 1, `overrun`=0.
- Abort/reset: drop `enable`, or assert `rst_n`=0, mid-ACTIVE → no record, state IDLE; reset clears all outputs to 0.

Source files
------------

// File: rtl/event_qualifier_pkg.sv
// event_qualifier_pkg: shared FSM encoding, default widths and the event record layout.
package event_qualifier_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, HOLDOFF} state_t;
  typedef struct packed {
    logic [LEN_W_DEF-1:0]        len;
    logic signed [WIDTH_DEF-1:0] peak;
  } evt_rec_t;
endpackage

// File: rtl/event_record_buf.sv
// event_record_buf: single-entry valid/ready record register with sticky overrun on drop.
module event_record_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic          clr_overrun,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data_out,
  output logic          overrun
);
  logic take;
  // a full buffer frees its slot on the same edge it hands off
  assign take = load && (!valid || ready);
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid    <= 1'b0;
      data_out <= '0;
      overrun  <= 1'b0;
    end else begin
      valid   <= take || (valid && !ready);
      if (take) data_out <= data_in;
      overrun <= (load && !take) || (overrun && !clr_overrun);
    end
endmodule

// File: rtl/event_qualifier.sv
// event_qualifier: debounces event_flag runs into {len, peak} records with a hold-off window.
// Peak tracking is built only when EVENT_PEAK_CAPTURE_EN is defined; otherwise evt_peak is 0.
module event_qualifier
  import event_qualifier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    event_flag,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic [CNT_W-1:0]        min_len,
  input  logic [CNT_W-1:0]        holdoff,
  input  logic                    clr_overrun,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [LEN_W-1:0]        evt_len,
  output logic signed [WIDTH-1:0] evt_peak,
  output logic [LEN_W-1:0]        evt_count,
  output logic                    overrun
);
  state_t state, state_nx;
  logic [LEN_W-1:0] run, run_inc;
  logic [CNT_W-1:0] timer, eff_min;
  logic emit;
  assign eff_min = (min_len == '0) ? CNT_W'(1) : min_len;
  assign run_inc = run + LEN_W'(1);
  always_ff @(posedge clk) state <= rst_n ? state_nx : IDLE;
  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else
      case (state)
        IDLE:    if (event_flag) state_nx = (eff_min <= CNT_W'(1)) ? ACTIVE : QUAL;
        QUAL:    state_nx = !event_flag ? IDLE : (run_inc >= LEN_W'(eff_min)) ? ACTIVE : QUAL;
        ACTIVE:  if (!event_flag) state_nx = (holdoff == '0) ? IDLE : HOLDOFF;
        HOLDOFF: if (timer == CNT_W'(1)) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end
  always_comb emit = enable && state == ACTIVE && !event_flag;
  // run/timer values outside their owning states are don't-care; entry states reload them
  always_ff @(posedge clk)
    if (!rst_n || !enable) begin
      run   <= '0;
      timer <= '0;
    end else begin
      run   <= (state == IDLE) ? LEN_W'(1) : (&run) ? run : run_inc;
      timer <= (state == ACTIVE) ? holdoff : timer - CNT_W'(1);
    end
  always_ff @(posedge clk) evt_count <= !rst_n ? '0 : evt_count + LEN_W'(emit);
`ifdef EVENT_PEAK_CAPTURE_EN
  localparam int DW = LEN_W + WIDTH;
  logic signed [WIDTH-1:0] peak;
  logic [DW-1:0] rec_in, rec_out;
  // strict compare keeps the earlier sample on ties
  always_ff @(posedge clk)
    if (!rst_n || !enable) peak <= '0;
    else peak <= (state == IDLE || sample_in > peak) ? sample_in : peak;
  assign rec_in = {run, peak};
  assign {evt_len, evt_peak} = rec_out;
`else
  localparam int DW = LEN_W;
  logic [DW-1:0] rec_in, rec_out;
  logic unused_sample;
  assign unused_sample = ^sample_in;
  assign rec_in = run;
  assign evt_len = rec_out;
  assign evt_peak = '0;
`endif
  event_record_buf #(.DW(DW)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (emit),
    .data_in     (rec_in),
    .clr_overrun (clr_overrun),
    .ready       (evt_ready),
    .valid       (evt_valid),
    .data_out    (rec_out),
    .overrun     (overrun)
  );
endmodule

// File: tb/tb_event_qualifier.sv
// tb_event_qualifier: table-driven runs plus hand sequences, records checked via a scoreboard queue.
module tb_event_qualifier;
`ifdef EVENT_PEAK_CAPTURE_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif
  logic clk, rst_n, enable, event_flag, clr_overrun, evt_valid, evt_ready, overrun;
  logic signed [15:0] sample_in, evt_peak;
  logic [7:0] min_len, holdoff;
  logic [15:0] evt_len, evt_count;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [31:0] q[$];
  logic [31:0] mon_e;

  typedef struct packed {
    logic [7:0]        ml;
    logic [3:0]        n;
    logic [0:7][15:0]  s;
    logic              acc;
    logic [15:0]       len;
    logic signed [15:0] pk;
  } vec_t;
  vec_t tbl [7];
  int gaps [3] = '{3, 5, 6};

  event_qualifier dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .event_flag(event_flag),
    .sample_in(sample_in), .min_len(min_len), .holdoff(holdoff),
    .clr_overrun(clr_overrun), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_len(evt_len), .evt_peak(evt_peak), .evt_count(evt_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic f, input logic signed [15:0] s);
    event_flag = f;
    sample_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0);
  endtask

  task automatic expect_rec(input logic [15:0] len, input logic signed [15:0] pk);
    q.push_back({len, PK ? pk : 16'sd0});
    exp_cnt++;
  endtask

  // handshake completes on the next rising edge; compare against the oldest expectation
  always @(negedge clk)
    if (rst_n && evt_valid && evt_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record len=%0d peak=%0d required=none", evt_len, evt_peak);
      end else begin
        mon_e = q.pop_front();
        chk("rec_len", evt_len, mon_e[31:16]);
        chk("rec_peak", evt_peak, $signed(mon_e[15:0]));
      end
    end

  initial begin
    tbl[0] = {8'd4, 4'd3, {16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b0, 16'd0, 16'sd0};
    tbl[1] = {8'd4, 4'd6, {16'd10, 16'd50, 16'd30, 16'd70, 16'd20, 16'd5, 16'd0, 16'd0}, 1'b1, 16'd6, 16'sd70};
    tbl[2] = {8'd0, 4'd1, {-16'sd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b1, 16'd1, -16'sd5};
    tbl[3] = {8'd1, 4'd2, {-16'sd100, -16'sd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b1, 16'd2, -16'sd3};
    tbl[4] = {8'd3, 4'd3, {-16'sd20, 16'd30, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b1, 16'd3, 16'sd30};
    tbl[5] = {8'd2, 4'd1, {16'd99, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b0, 16'd0, 16'sd0};
    tbl[6] = {8'd5, 4'd8, {16'h8000, 16'd100, 16'h7FFF, 16'd0, 16'hFFFF, 16'd5, 16'd6, 16'd7}, 1'b1, 16'd8, 16'sh7FFF};
    rst_n = 1'b0; enable = 1'b1; event_flag = 1'b0; sample_in = '0;
    min_len = 8'd1; holdoff = 8'd0; clr_overrun = 1'b0; evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_len", evt_len, 0);
    chk("rst_peak", evt_peak, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 7; i++) begin
      min_len = tbl[i].ml;
      for (int j = 0; j < int'(tbl[i].n); j++) tick(1'b1, $signed(tbl[i].s[j]));
      if (tbl[i].acc) expect_rec(tbl[i].len, tbl[i].pk);
      idle(3);
      chk("tbl_count", evt_count, exp_cnt);
      chk("tbl_drained", q.size(), 0);
    end

    min_len = 8'd4;
    holdoff = 8'd5;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) tick(1'b1, 16'(j + 1));
      expect_rec(16'd4, 16'sd4);
      idle(gaps[k]);
      for (int j = 0; j < 4; j++) tick(1'b1, 16'(j + 20));
      if (gaps[k] == 6) expect_rec(16'd4, 16'sd23);
      idle(8);
      chk("holdoff_count", evt_count, exp_cnt);
      chk("holdoff_drained", q.size(), 0);
    end

    holdoff = 8'd0;
    min_len = 8'd1;
    evt_ready = 1'b0;
    tick(1'b1, 16'sd11); tick(1'b1, 16'sd12);
    expect_rec(16'd2, 16'sd12);
    idle(2);
    chk("bp_valid_held", evt_valid, 1);
    chk("bp_no_overrun", overrun, 0);
    tick(1'b1, 16'sd40); tick(1'b1, 16'sd41); tick(1'b1, 16'sd42);
    exp_cnt++;
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    chk("bp_overrun_wins_clr", overrun, 1);
    chk("bp_count", evt_count, exp_cnt);
    chk("bp_len_kept", evt_len, 2);
    chk("bp_peak_kept", evt_peak, PK ? 12 : 0);
    evt_ready = 1'b1;
    idle(1);
    chk("bp_valid_drop", evt_valid, 0);
    chk("bp_drained", q.size(), 0);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    chk("bp_overrun_clr", overrun, 0);

    evt_ready = 1'b0;
    tick(1'b1, 16'sd3); tick(1'b1, 16'sd4);
    expect_rec(16'd2, 16'sd4);
    idle(1);
    tick(1'b1, 16'sd9); tick(1'b1, 16'sd8); tick(1'b1, 16'sd7);
    expect_rec(16'd3, 16'sd9);
    evt_ready = 1'b1;
    idle(1);
    evt_ready = 1'b0;
    chk("sim_valid_stays", evt_valid, 1);
    chk("sim_len_new", evt_len, 3);
    chk("sim_no_overrun", overrun, 0);
    chk("sim_count", evt_count, exp_cnt);
    evt_ready = 1'b1;
    idle(1);
    chk("sim_valid_drop", evt_valid, 0);
    chk("sim_drained", q.size(), 0);

    repeat (3) tick(1'b1, 16'sd5);
    enable = 1'b0;
    tick(1'b1, 16'sd6);
    enable = 1'b1;
    idle(2);
    tick(1'b1, 16'sd1); tick(1'b1, 16'sd2);
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(2);
    chk("abort_count", evt_count, exp_cnt);
    chk("abort_valid", evt_valid, 0);

    evt_ready = 1'b0;
    tick(1'b1, 16'sd1); idle(1);
    tick(1'b1, 16'sd2); idle(1);
    chk("pre_rst_overrun", overrun, 1);
    tick(1'b1, 16'sd3); tick(1'b1, 16'sd4);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    exp_cnt = 0;
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_len", evt_len, 0);
    chk("mid_rst_peak", evt_peak, 0);
    chk("mid_rst_count", evt_count, 0);
    chk("mid_rst_overrun", overrun, 0);
    idle(1);
    chk("post_rst_idle", evt_valid, 0);
    evt_ready = 1'b1;
    tick(1'b1, 16'sd77);
    expect_rec(16'd1, 16'sd77);
    idle(3);
    chk("post_rst_count", evt_count, exp_cnt);
    chk("final_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
